coax_link_ctrl: RTL and testbench
=================================

Name: coax_link_ctrl

Overview:
- Half-duplex transaction sequencer for the 3270 coax link.
- Sits between host logic and the coax_tx / coax_rx datapath. It starts a transmit, gates the receiver during transmit and turnaround, and waits for the terminal response with a timeout.
- Counts response words, recovers coax_rx from ERROR by pulsing its reset, and reports a per-transaction status.

Parameters:
- CLOCKS_PER_BIT, 8, clock cycles per coax bit time; must match coax_rx/coax_tx.
- TURNAROUND_BITS, 2, bit times the line is left quiet after tx_active falls before the receiver is enabled.
- RESPONSE_TIMEOUT_BITS, 64, bit times allowed from receiver enable to rx_active rising.
- RX_RESET_CYCLES, 2, width in cycles of the rx_reset pulse.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a transaction; honoured only in IDLE
- expect_response  in  1  sampled together with start; 0 = transmit-only transaction
- busy  out  1  high in every state except IDLE
- tx_start  out  1  one-cycle pulse to coax_tx
- tx_active  in  1  coax_tx is driving the line
- rx_enable  out  1  receiver qualification; high only in RX_WAIT and RX
- rx_active  in  1  coax_rx is receiving a frame
- rx_strobe  in  1  one-cycle pulse per received word
- rx_error  in  1  coax_rx is in its ERROR state
- rx_reset  out  1  active-high reset to coax_rx
- done  out  1  one-cycle completion pulse
- status  out  2  0 = OK, 1 = TIMEOUT, 2 = RX_ERROR, 3 = TX_FAULT; valid from done until the next start
- word_count  out  8  number of response words; saturates at 255

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset is asynchronous and overrides everything, including mid-transaction; no done pulse is produced on reset.

States and transitions:
- IDLE: on start, latch expect_response, clear word_count and status, assert tx_start for exactly 1 cycle, then go to TX_WAIT.
  - A start that arrives while busy is ignored.
- TX_WAIT: wait for tx_active to rise.
  - If it has not risen within 4*CLOCKS_PER_BIT cycles: status = TX_FAULT, go to DONE.
  - On rising edge: go to TX.
- TX: stay while tx_active = 1. On tx_active = 0:
  - if the latched expect_response = 0, go to DONE with status OK;
  - otherwise go to TURNAROUND.
- TURNAROUND: wait exactly TURNAROUND_BITS*CLOCKS_PER_BIT cycles (16 at defaults), then go to RX_WAIT.
- RX_WAIT: rx_enable = 1; the timeout counter counts from 0.
  - rx_active = 1: go to RX.
  - Counter reaches RESPONSE_TIMEOUT_BITS*CLOCKS_PER_BIT (512 at defaults): status = TIMEOUT, go to DONE.
  - rx_error = 1: go to RECOVER.
- RX: rx_enable = 1.
  - Each rx_strobe increments word_count, saturating at 255.
  - rx_error = 1: go to RECOVER. rx_error has priority over a simultaneous rx_strobe; that strobe is still counted.
  - rx_active falling with no error: status OK, go to DONE.
- RECOVER: rx_reset = 1 for RX_RESET_CYCLES cycles, rx_enable = 0, status = RX_ERROR, then go to DONE.
- DONE: done = 1 for 1 cycle, then go to IDLE.

Other rules:
- rx_error seen in any state other than RX_WAIT or RX is ignored, because the receiver is not qualified then.
- word_count and status are held until the next accepted start.
- Total latency for a transmit-only transaction: done rises 2 cycles after tx_active falls.

Optional Feature:
- Macro: COAX_LINK_CTRL_RETRY_EN.
- Defined: a TIMEOUT or RX_ERROR outcome (after RECOVER completes) triggers exactly one automatic retry.
  - The retry re-enters IDLE-equivalent issue: tx_start pulses again 1 cycle later, word_count is cleared, busy stays high throughout.
  - done is pulsed only after the final attempt.
  - Output retried (1 bit) goes high when a retry occurred; it resets to 0 and clears on start.
- Not defined: no retry; the first failure is reported; the retried port is absent.

Test Plan:
- Reset and idle: assert reset_n = 0 mid-TX, then release -> all outputs 0, busy = 0, state IDLE, no done pulse.
- Transmit-only: start with expect_response = 0; model tx_active high for 96 cycles -> one tx_start pulse; done exactly 2 cycles after tx_active falls; status = 0; rx_enable never high.
- Normal response: start with expect_response = 1; after TX, rx_active rises 40 cycles after rx_enable rises; 3 rx_strobe pulses; rx_active falls -> rx_enable rises exactly 16 cycles after tx_active falls; word_count = 3; status = 0; one done pulse.
- Timeout: no rx_active after TX -> done 512 cycles after rx_enable rises; status = 1; word_count = 0.
- Receiver error: rx_error asserted during RX after 1 strobe -> rx_reset high for 2 cycles; status = 2; word_count = 1; rx_enable low during RECOVER.
- TX fault and ignored start: tx_active never rises -> status = 3 after 32 cycles; a second start pulse during busy produces no extra tx_start. With COAX_LINK_CTRL_RETRY_EN defined, a timeout on the first attempt followed by success -> two tx_start pulses, a single done, status = 0, retried = 1.

Source files
------------

// File: rtl/coax_link_ctrl.sv
// Half-duplex 3270 coax transaction sequencer: tx start, turnaround, response wait, rx recovery.
// Optional automatic single retry on TIMEOUT / RX_ERROR when COAX_LINK_CTRL_RETRY_EN is defined.
module coax_link_ctrl #(
  parameter int CLOCKS_PER_BIT        = 8,
  parameter int TURNAROUND_BITS       = 2,
  parameter int RESPONSE_TIMEOUT_BITS = 64,
  parameter int RX_RESET_CYCLES       = 2
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  logic       expect_response_i,
  output logic       busy_o,
  output logic       tx_start_o,
  input  logic       tx_active_i,
  output logic       rx_enable_o,
  input  logic       rx_active_i,
  input  logic       rx_strobe_i,
  input  logic       rx_error_i,
  output logic       rx_reset_o,
  output logic       done_o,
  output logic [1:0] status_o,
  output logic [7:0] word_count_o
`ifdef COAX_LINK_CTRL_RETRY_EN
  ,
  output logic       retried_o
`endif
);

  localparam int TMR_W       = 16;
  localparam int TX_WAIT_CYC = 4 * CLOCKS_PER_BIT;
  localparam int TURN_CYC    = TURNAROUND_BITS * CLOCKS_PER_BIT;
  localparam int RESP_CYC    = RESPONSE_TIMEOUT_BITS * CLOCKS_PER_BIT;

  // Input sampling register plus the TX exit cycle consume 3 cycles of the turnaround,
  // so rx_enable rises exactly TURN_CYC cycles after tx_active falls on the pin.
  localparam logic [TMR_W-1:0] TX_WAIT_LOAD = TMR_W'(TX_WAIT_CYC - 1);
  localparam logic [TMR_W-1:0] TURN_LOAD    = TMR_W'(TURN_CYC - 3);
  localparam logic [TMR_W-1:0] RESP_LOAD    = TMR_W'(RESP_CYC - 1);
  localparam logic [TMR_W-1:0] RST_LOAD     = TMR_W'(RX_RESET_CYCLES - 1);

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_TIMEOUT  = 2'd1;
  localparam logic [1:0] ST_RX_ERROR = 2'd2;
  localparam logic [1:0] ST_TX_FAULT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_TX_WAIT, S_TX, S_TURN, S_RX_WAIT, S_RX, S_RECOVER, S_DONE
  } state_e;

  state_e            state_q;
  logic [TMR_W-1:0]  timer_q;
  logic              expect_resp_q;
  logic              tx_act_q, rx_act_q, rx_stb_q, rx_err_q;
  logic              busy_q, tx_start_q, rx_en_q, rx_rst_q, done_q;
  logic [1:0]        status_q;
  logic [7:0]        word_count_q;
  logic [7:0]        word_count_d;
  logic              retry_avail;

  assign word_count_d = (word_count_q == 8'hFF) ? word_count_q : word_count_q + 8'd1;

`ifdef COAX_LINK_CTRL_RETRY_EN
  logic retried_q;
  assign retry_avail = ~retried_q;
  assign retried_o   = retried_q;
`else
  assign retry_avail = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      expect_resp_q <= 1'b0;
      tx_act_q      <= 1'b0;
      rx_act_q      <= 1'b0;
      rx_stb_q      <= 1'b0;
      rx_err_q      <= 1'b0;
      busy_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      rx_en_q       <= 1'b0;
      rx_rst_q      <= 1'b0;
      done_q        <= 1'b0;
      status_q      <= ST_OK;
      word_count_q  <= '0;
`ifdef COAX_LINK_CTRL_RETRY_EN
      retried_q     <= 1'b0;
`endif
    end else begin
      tx_act_q   <= tx_active_i;
      rx_act_q   <= rx_active_i;
      rx_stb_q   <= rx_strobe_i;
      rx_err_q   <= rx_error_i;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            expect_resp_q <= expect_response_i;
            word_count_q  <= '0;
            status_q      <= ST_OK;
            busy_q        <= 1'b1;
            tx_start_q    <= 1'b1;
            timer_q       <= TX_WAIT_LOAD;
            state_q       <= S_TX_WAIT;
`ifdef COAX_LINK_CTRL_RETRY_EN
            retried_q     <= 1'b0;
`endif
          end
        end
        S_TX_WAIT: begin
          if (tx_act_q) begin
            state_q <= S_TX;
          end else if (timer_q == '0) begin
            status_q <= ST_TX_FAULT;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_TX: begin
          if (!tx_act_q) begin
            if (expect_resp_q) begin
              timer_q <= TURN_LOAD;
              state_q <= S_TURN;
            end else begin
              status_q <= ST_OK;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end
        S_TURN: begin
          if (timer_q == '0) begin
            rx_en_q <= 1'b1;
            timer_q <= RESP_LOAD;
            state_q <= S_RX_WAIT;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_RX_WAIT: begin
          if (rx_err_q) begin
            rx_en_q  <= 1'b0;
            rx_rst_q <= 1'b1;
            status_q <= ST_RX_ERROR;
            timer_q  <= RST_LOAD;
            state_q  <= S_RECOVER;
          end else if (rx_act_q) begin
            if (rx_stb_q) word_count_q <= word_count_d;
            state_q <= S_RX;
          end else if (timer_q == '0) begin
            rx_en_q <= 1'b0;
            if (retry_avail) begin
              word_count_q <= '0;
              status_q     <= ST_OK;
              tx_start_q   <= 1'b1;
              timer_q      <= TX_WAIT_LOAD;
              state_q      <= S_TX_WAIT;
`ifdef COAX_LINK_CTRL_RETRY_EN
              retried_q    <= 1'b1;
`endif
            end else begin
              status_q <= ST_TIMEOUT;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_RX: begin
          if (rx_stb_q) word_count_q <= word_count_d;
          if (rx_err_q) begin
            rx_en_q  <= 1'b0;
            rx_rst_q <= 1'b1;
            status_q <= ST_RX_ERROR;
            timer_q  <= RST_LOAD;
            state_q  <= S_RECOVER;
          end else if (!rx_act_q) begin
            rx_en_q  <= 1'b0;
            status_q <= ST_OK;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_RECOVER: begin
          if (timer_q == '0) begin
            rx_rst_q <= 1'b0;
            if (retry_avail) begin
              word_count_q <= '0;
              status_q     <= ST_OK;
              tx_start_q   <= 1'b1;
              timer_q      <= TX_WAIT_LOAD;
              state_q      <= S_TX_WAIT;
`ifdef COAX_LINK_CTRL_RETRY_EN
              retried_q    <= 1'b1;
`endif
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign tx_start_o   = tx_start_q;
  assign rx_enable_o  = rx_en_q;
  assign rx_reset_o   = rx_rst_q;
  assign done_o       = done_q;
  assign status_o     = status_q;
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_coax_link_ctrl.sv
// Directed/randomized bench for coax_link_ctrl; expected timing comes from the link timing rules.
`timescale 1ns/1ps
module tb_coax_link_ctrl;
  localparam int CPB  = 8;
  localparam int TURN = 2 * CPB;
  localparam int RESP = 64 * CPB;
  localparam int TXW  = 4 * CPB;
  localparam int RSTC = 2;

  logic clk = 1'b0, reset_n = 1'b1, start = 1'b0, expect_resp = 1'b0;
  logic tx_active = 1'b0, rx_active = 1'b0, rx_strobe = 1'b0, rx_error = 1'b0;
  logic busy, tx_start, rx_enable, rx_reset, done;
  logic [1:0] status;
  logic [7:0] word_count;
`ifdef COAX_LINK_CTRL_RETRY_EN
  logic retried;
`endif

  int tests = 0, fails = 0;
  int cyc = 0;
  int tx_start_cnt = 0, tx_start_cyc = 0, done_cnt = 0, done_cyc = 0;
  int rxen_cnt = 0, rxen_rise_cyc = 0, rxen_hi = 0, rxrst_hi = 0, overlap = 0;
  logic rxen_prev = 1'b0;

  coax_link_ctrl dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .expect_response_i(expect_resp),
    .busy_o(busy), .tx_start_o(tx_start), .tx_active_i(tx_active), .rx_enable_o(rx_enable),
    .rx_active_i(rx_active), .rx_strobe_i(rx_strobe), .rx_error_i(rx_error),
    .rx_reset_o(rx_reset), .done_o(done), .status_o(status), .word_count_o(word_count)
`ifdef COAX_LINK_CTRL_RETRY_EN
    , .retried_o(retried)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_start === 1'b1) begin tx_start_cnt <= tx_start_cnt + 1; tx_start_cyc <= cyc; end
    if (done === 1'b1) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (rx_enable === 1'b1 && !rxen_prev) begin rxen_cnt <= rxen_cnt + 1; rxen_rise_cyc <= cyc; end
    if (rx_enable === 1'b1) rxen_hi <= rxen_hi + 1;
    if (rx_reset === 1'b1) rxrst_hi <= rxrst_hi + 1;
    if (rx_reset === 1'b1 && rx_enable === 1'b1) overlap <= overlap + 1;
    rxen_prev <= (rx_enable === 1'b1);
  end

  initial begin
    #2_000_000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic exp_r);
    start = 1'b1; expect_resp = exp_r;
    tick(1);
    start = 1'b0; expect_resp = 1'b0;
  endtask

  task automatic run_tx(input int gap, input int len, output int fall);
    tick(gap);
    tx_active = 1'b1;
    tick(len);
    tx_active = 1'b0;
    fall = cyc;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int d0; int i;
    d0 = done_cnt; i = 0;
    while (done_cnt == d0 && i < bound) begin tick(1); i++; end
    check(tag, 32'(done_cnt != d0), 1);
  endtask

  task automatic wait_rxen(input string tag, input int bound);
    int r0; int i;
    r0 = rxen_cnt; i = 0;
    while (rxen_cnt == r0 && i < bound) begin tick(1); i++; end
    check(tag, 32'(rxen_cnt != r0), 1);
  endtask

  task automatic strobes(input int n);
    for (int s = 0; s < n; s++) begin
      rx_strobe = 1'b1; tick(1); rx_strobe = 1'b0;
      tick($urandom_range(3, 1));
    end
  endtask

  initial begin
    int fall, n, d, len, ts0, d0, r0, rs0, ov0, wc_exp;

    #2 reset_n = 1'b0;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_rx_enable", rx_enable, 0);
    check("rst_rx_reset", rx_reset, 0);
    check("rst_done", done, 0);
    check("rst_status", status, 0);
    check("rst_word_count", word_count, 0);
    reset_n = 1'b1;
    tick(2);

    // transmit-only transactions
    for (int k = 0; k < 3; k++) begin
      len = (k == 0) ? 96 : int'($urandom_range(120, 10));
      ts0 = tx_start_cnt; d0 = done_cnt; r0 = rxen_hi;
      pulse_start(1'b0);
      check("txo_busy", busy, 1);
      run_tx($urandom_range(10, 1), len, fall);
      wait_done("txo_done_seen", 20);
      check("txo_latency", done_cyc - fall, 2);
      check("txo_status", status, 0);
      check("txo_word_count", word_count, 0);
      tick(3);
      check("txo_tx_start_cnt", tx_start_cnt - ts0, 1);
      check("txo_done_cnt", done_cnt - d0, 1);
      check("txo_rxen_never", rxen_hi - r0, 0);
      check("txo_idle", busy, 0);
    end

    // response transactions, last one saturates word_count
    for (int k = 0; k < 4; k++) begin
      n = (k == 0) ? 3 : (k == 3) ? 260 : int'($urandom_range(8, 0));
      d = (k == 0) ? 40 : int'($urandom_range(300, 1));
      wc_exp = (n > 255) ? 255 : n;
      ts0 = tx_start_cnt; d0 = done_cnt;
      pulse_start(1'b1);
      run_tx($urandom_range(10, 1), $urandom_range(100, 10), fall);
      wait_rxen("rsp_rxen_seen", TURN + 10);
      check("rsp_turnaround", rxen_rise_cyc - fall, TURN);
      tick(d - 1);
      rx_active = 1'b1;
      tick(2);
      strobes(n);
      rx_active = 1'b0;
      wait_done("rsp_done_seen", 20);
      check("rsp_status", status, 0);
      check("rsp_word_count", word_count, wc_exp);
      check("rsp_rxen_low", rx_enable, 0);
      tick(3);
      check("rsp_tx_start_cnt", tx_start_cnt - ts0, 1);
      check("rsp_done_cnt", done_cnt - d0, 1);
    end

`ifndef COAX_LINK_CTRL_RETRY_EN
    // response timeout
    d0 = done_cnt;
    pulse_start(1'b1);
    run_tx($urandom_range(10, 1), $urandom_range(60, 10), fall);
    wait_rxen("to_rxen_seen", TURN + 10);
    wait_done("to_done_seen", RESP + 20);
    check("to_latency", done_cyc - rxen_rise_cyc, RESP);
    check("to_status", status, 1);
    check("to_word_count", word_count, 0);
    check("to_rxen_low", rx_enable, 0);
    tick(3);
    check("to_done_cnt", done_cnt - d0, 1);

    // receiver error; second case has a strobe coincident with the error
    for (int k = 0; k < 2; k++) begin
      pulse_start(1'b1);
      run_tx($urandom_range(10, 1), $urandom_range(60, 10), fall);
      wait_rxen("err_rxen_seen", TURN + 10);
      tick($urandom_range(50, 1));
      rx_active = 1'b1;
      tick(2);
      strobes(1);
      tick(2);
      rs0 = rxrst_hi; ov0 = overlap;
      rx_error = 1'b1;
      if (k == 1) rx_strobe = 1'b1;
      tick(1);
      rx_strobe = 1'b0;
      wait_done("err_done_seen", 20);
      rx_error = 1'b0; rx_active = 1'b0;
      check("err_rx_reset_width", rxrst_hi - rs0, RSTC);
      check("err_rxen_during_recover", overlap - ov0, 0);
      check("err_status", status, 2);
      check("err_word_count", word_count, (k == 1) ? 2 : 1);
      tick(3);
    end
`endif

    // tx fault with an ignored second start
    ts0 = tx_start_cnt;
    pulse_start(1'b0);
    tick(5);
    pulse_start(1'b1);
    wait_done("flt_done_seen", TXW + 20);
    check("flt_latency", done_cyc - tx_start_cyc, TXW);
    check("flt_status", status, 3);
    check("flt_tx_start_cnt", tx_start_cnt - ts0, 1);
    tick(3);

`ifdef COAX_LINK_CTRL_RETRY_EN
    // timeout on first attempt, success on the retry
    ts0 = tx_start_cnt; d0 = done_cnt;
    pulse_start(1'b1);
    run_tx(2, 40, fall);
    wait_rxen("rty_rxen1_seen", TURN + 10);
    for (int i = 0; i < RESP + 20 && tx_start_cnt - ts0 < 2; i++) tick(1);
    check("rty_second_tx_start", tx_start_cnt - ts0, 2);
    check("rty_busy", busy, 1);
    check("rty_flag_set", retried, 1);
    run_tx(2, 30, fall);
    wait_rxen("rty_rxen2_seen", TURN + 10);
    tick(10);
    rx_active = 1'b1;
    tick(2);
    strobes(2);
    rx_active = 1'b0;
    wait_done("rty_done_seen", 20);
    check("rty_status", status, 0);
    check("rty_word_count", word_count, 2);
    check("rty_done_cnt", done_cnt - d0, 1);
    check("rty_flag_held", retried, 1);
    tick(3);
    pulse_start(1'b0);
    check("rty_flag_cleared", retried, 0);
    run_tx(2, 20, fall);
    wait_done("rty_txo_done_seen", 20);
    tick(3);
`endif

    // reset mid-TX
    ts0 = tx_start_cnt; d0 = done_cnt;
    pulse_start(1'b1);
    tick(2);
    tx_active = 1'b1;
    tick(20);
    reset_n = 1'b0;
    #1;
    check("rstx_busy", busy, 0);
    check("rstx_tx_start", tx_start, 0);
    check("rstx_rx_enable", rx_enable, 0);
    check("rstx_rx_reset", rx_reset, 0);
    check("rstx_done", done, 0);
    check("rstx_status", status, 0);
    check("rstx_word_count", word_count, 0);
    tick(3);
    tx_active = 1'b0;
    reset_n = 1'b1;
    tick(40);
    check("rstx_no_done", done_cnt - d0, 0);
    check("rstx_tx_start_cnt", tx_start_cnt - ts0, 1);
    check("rstx_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
